// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 MSB-first byte responder, oversampled in the clk domain,
// with one-deep valid/ready TX and RX holding registers and sticky error flags.
module spi_slave #(
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              err_underrun,
  output logic              err_overrun,
  input  logic              err_clr
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
  logic rise, fall, shifting, load_tx, word_done, capture, tx_full;
  logic [DATA_W-1:0] tx_sh, rx_sh, tx_hold;
  logic [CW-1:0] bit_cnt;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rise = ~ss_s & sclk_s & ~sclk_d;
  assign fall = ~ss_s & ~sclk_s & sclk_d;
  assign shifting = state == SHIFT;
  // Word boundaries come from the bit counter alone, so words can run back-to-back in one frame.
  assign load_tx = (state == LOAD) | (shifting & fall & (bit_cnt == CW'(DATA_W)));
  assign word_done = shifting & rise & (bit_cnt == CW'(DATA_W - 1));
  assign capture = tx_valid & ~tx_full;
  assign tx_ready = ~tx_full;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      ss_q <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      ss_q <= {ss_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d <= sclk_s;
      ss_d <= ss_s;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = ss_s ? IDLE : (state == IDLE) ? (ss_d ? LOAD : IDLE) : SHIFT;
  end
  always_comb begin
    busy = state != IDLE;
    spi_miso_oe = busy;
    spi_miso = tx_sh[DATA_W-1];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sh <= '0;
      rx_sh <= '0;
      bit_cnt <= '0;
      tx_hold <= '0;
      tx_full <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      err_underrun <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (load_tx) tx_sh <= tx_full ? tx_hold : IDLE_BYTE;
      else if (shifting & fall) tx_sh <= tx_sh << 1;
      if (load_tx) bit_cnt <= '0;
      else if (shifting & rise) bit_cnt <= bit_cnt + 1'b1;
      if (shifting & rise) rx_sh <= {rx_sh[DATA_W-2:0], mosi_s};
      if (capture) tx_hold <= tx_data;
      tx_full <= capture | (tx_full & ~load_tx);
      if (word_done) rx_data <= {rx_sh[DATA_W-2:0], mosi_s};
      rx_valid <= word_done | (rx_valid & ~rx_ready);
      err_underrun <= (load_tx & ~tx_full) | (err_underrun & ~err_clr);
      err_overrun <= (word_done & rx_valid & ~rx_ready) | (err_overrun & ~err_clr);
    end
  end
endmodule
